// File: rtl/photon_lockin_pkg.sv
// Shared phase encoding and width helpers for the photon lock-in counter.
package photon_lockin_pkg;
    localparam logic PHASE_OFF = 1'b0;
    localparam logic PHASE_ON  = 1'b1;

    function automatic int result_width(input int cnt_w);
        return cnt_w + 1;
    endfunction

    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction
endpackage

// File: rtl/photon_channel_counter.sv
// Per-channel PMT synchroniser, phase-sorted saturating counters, window snapshot and pulse train.
// Latency: an edge is counted SYNC_STAGES+1 cycles after sampling; result one cycle after window_end.
// Backpressure: none; a snapshot is taken every window whether or not it is consumed.
module photon_channel_counter
    import photon_lockin_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
)(
    input  logic                            clock_50_mhz,
    input  logic                            reset_n,
    input  logic                            pmt_in,
    input  logic                            phase,
    input  logic                            blank,
    input  logic                            window_end,
    output logic [result_width(CNT_W)-1:0]  result_diff,
    output logic                            pulse_out_pin
);
    localparam int               RES_W   = result_width(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   edge_q;
    logic [CNT_W-1:0]       add_cnt;
    logic [CNT_W-1:0]       sub_cnt;
    logic [CNT_W-1:0]       pulse_cnt;
    logic [CNT_W-1:0]       pulse_load;
    logic [RES_W-1:0]       diff_next;
    logic                   count_add;
    logic                   count_sub;

    assign count_add  = edge_q && phase == PHASE_ON  && !blank;
    assign count_sub  = edge_q && phase == PHASE_OFF && !blank;
    // Zero-extended subtraction is exact in CNT_W+1 bits; the MSB is the sign.
    assign diff_next  = {1'b0, add_cnt} - {1'b0, sub_cnt};
    assign pulse_load = diff_next[RES_W-1] ? '0 : diff_next[CNT_W-1:0];

    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= '0;
            sync_d        <= 1'b0;
            edge_q        <= 1'b0;
            add_cnt       <= '0;
            sub_cnt       <= '0;
            pulse_cnt     <= '0;
            result_diff   <= '0;
            pulse_out_pin <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], pmt_in};
            sync_d        <= sync_q[SYNC_STAGES-1];
            edge_q        <= sync_q[SYNC_STAGES-1] & ~sync_d;
            pulse_out_pin <= (pulse_cnt != '0);
            if (window_end) begin
                result_diff <= diff_next;
                // An edge landing on the boundary seeds the next window.
                add_cnt     <= CNT_W'(count_add);
                sub_cnt     <= CNT_W'(count_sub);
                pulse_cnt   <= pulse_load;
            end else begin
                if (count_add && add_cnt != CNT_MAX)
                    add_cnt <= add_cnt + 1'b1;
                if (count_sub && sub_cnt != CNT_MAX)
                    sub_cnt <= sub_cnt + 1'b1;
                if (pulse_cnt != '0)
                    pulse_cnt <= pulse_cnt - 1'b1;
            end
        end
    end
endmodule

// File: rtl/photon_lockin_counter.sv
// Multi-channel lock-in photon counter: light modulation, optional blanking (LOCKIN_BLANKING_EN), window timing.
// Latency: window result and result_valid appear the cycle after the window-end cycle.
// Backpressure: none; an unaccepted result is overwritten and flagged by the sticky overrun bit.
module photon_lockin_counter
    import photon_lockin_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int CNT_W           = 32,
    parameter int MOD_HALF_PERIOD = 500000,
    parameter int INTEG_CYCLES    = 50000000,
    parameter int BLANK_CYCLES    = 16,
    parameter int SYNC_STAGES     = 2
)(
    input  logic                                    clock_50_mhz,
    input  logic                                    reset_n,
    input  logic [NUM_CH-1:0]                       pmt_in,
    output logic                                    light_source_pin,
    output logic [NUM_CH*result_width(CNT_W)-1:0]   result_diff,
    output logic                                    result_valid,
    input  logic                                    result_ready,
    output logic                                    overrun,
    output logic [NUM_CH-1:0]                       pulse_out_pin
);
    localparam int RES_W   = result_width(CNT_W);
    localparam int MOD_W   = $clog2(MOD_HALF_PERIOD);
    localparam int INTEG_W = $clog2(INTEG_CYCLES);

    logic [MOD_W-1:0]     mod_timer;
    logic [INTEG_W-1:0]   integ_timer;
    logic [SYNC_STAGES:0] phase_dly;
    logic                 mod_wrap;
    logic                 window_end;
    logic                 blank_dly;

    assign mod_wrap   = (mod_timer == MOD_W'(MOD_HALF_PERIOD - 1));
    assign window_end = (integ_timer == INTEG_W'(INTEG_CYCLES - 1));

    // phase_dly matches synchroniser + registered edge detect so each edge carries its pin-time phase.
    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            mod_timer        <= '0;
            integ_timer      <= '0;
            light_source_pin <= PHASE_OFF;
            phase_dly        <= '0;
        end else begin
            mod_timer   <= mod_wrap ? '0 : mod_timer + 1'b1;
            integ_timer <= window_end ? '0 : integ_timer + 1'b1;
            if (mod_wrap)
                light_source_pin <= ~light_source_pin;
            phase_dly <= {phase_dly[SYNC_STAGES-1:0], light_source_pin};
        end
    end

`ifdef LOCKIN_BLANKING_EN
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 2);

    logic [BLANK_W-1:0]   blank_timer;
    logic [SYNC_STAGES:0] blank_pipe;

    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            blank_timer <= '0;
            blank_pipe  <= '0;
        end else begin
            if (mod_wrap)
                blank_timer <= BLANK_W'(BLANK_CYCLES);
            else if (blank_timer != '0)
                blank_timer <= blank_timer - 1'b1;
            blank_pipe <= {blank_pipe[SYNC_STAGES-1:0], blank_timer != '0};
        end
    end

    assign blank_dly = blank_pipe[SYNC_STAGES];
`else
    logic blank_cycles_unused;
    assign blank_cycles_unused = |BLANK_CYCLES;
    assign blank_dly           = 1'b0;
`endif

    // A window end coinciding with a transfer keeps valid high with the new data.
    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (window_end) begin
            result_valid <= 1'b1;
            if (result_valid && !result_ready)
                overrun <= 1'b1;
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        photon_channel_counter #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clock_50_mhz  (clock_50_mhz),
            .reset_n       (reset_n),
            .pmt_in        (pmt_in[ch]),
            .phase         (phase_dly[SYNC_STAGES]),
            .blank         (blank_dly),
            .window_end    (window_end),
            .result_diff   (result_diff[ch*RES_W +: RES_W]),
            .pulse_out_pin (pulse_out_pin[ch])
        );
    end
endmodule

// File: tb/tb_photon_lockin_counter.sv
// Bench for photon_lockin_counter: per-window expected differences queued at stimulus time, compared on result.
module tb_photon_lockin_counter;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int RES_W  = CNT_W + 1;
    localparam int VEC_W  = NUM_CH * RES_W;

    logic               clock_50_mhz = 1'b0;
    logic               reset_n;
    logic [NUM_CH-1:0]  pmt_in;
    logic [NUM_CH-1:0]  pmt_sat;
    logic               result_ready;
    logic               sat_ready;
    logic               light_source_pin, result_valid, overrun;
    logic [VEC_W-1:0]   result_diff;
    logic [NUM_CH-1:0]  pulse_out_pin;
    logic               sat_light, sat_valid, sat_overrun;
    logic [VEC_W-1:0]   sat_diff;
    logic [NUM_CH-1:0]  sat_pulse;

    int checks = 0;
    int errors = 0;
    int cyc;
    int exp_add [4][NUM_CH];
    int exp_sub [4][NUM_CH];
    logic [VEC_W-1:0] exp_q [$];

    always #5 clock_50_mhz = ~clock_50_mhz;

    // cyc at a falling edge is the index of the next rising edge since reset release
    always @(posedge clock_50_mhz or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    photon_lockin_counter #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MOD_HALF_PERIOD(10),
        .INTEG_CYCLES(100), .BLANK_CYCLES(2), .SYNC_STAGES(2)
    ) dut (
        .clock_50_mhz(clock_50_mhz), .reset_n(reset_n), .pmt_in(pmt_in),
        .light_source_pin(light_source_pin), .result_diff(result_diff),
        .result_valid(result_valid), .result_ready(result_ready),
        .overrun(overrun), .pulse_out_pin(pulse_out_pin)
    );

    photon_lockin_counter #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MOD_HALF_PERIOD(700),
        .INTEG_CYCLES(1400), .BLANK_CYCLES(2), .SYNC_STAGES(2)
    ) dut_sat (
        .clock_50_mhz(clock_50_mhz), .reset_n(reset_n), .pmt_in(pmt_sat),
        .light_source_pin(sat_light), .result_diff(sat_diff),
        .result_valid(sat_valid), .result_ready(sat_ready),
        .overrun(sat_overrun), .pulse_out_pin(sat_pulse)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic clear_model();
        exp_q.delete();
        for (int w = 0; w < 4; w++)
            for (int ch = 0; ch < NUM_CH; ch++) begin
                exp_add[w][ch] = 0;
                exp_sub[w][ch] = 0;
            end
    endtask

    task automatic do_reset();
        @(negedge clock_50_mhz);
        reset_n      = 1'b0;
        pmt_in       = '0;
        pmt_sat      = '0;
        result_ready = 1'b1;
        clear_model();
        repeat (2) @(negedge clock_50_mhz);
        reset_n = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        int budget = 0;
        if (cyc > n) begin
            checks++; errors++;
            $display("FAIL wait_cyc: already at cyc %0d, required <= %0d", cyc, n);
        end
        while (cyc < n && budget < 5000) begin
            @(negedge clock_50_mhz);
            budget++;
        end
    endtask

    // One-cycle pulse sampled at rising edge n; phase, blanking and window come from n alone.
    task automatic drive(input int ch, input int n);
        int w;
        bit on, blanked;
        wait_cyc(n);
        pmt_in[ch] = 1'b1;
        @(negedge clock_50_mhz);
        pmt_in[ch] = 1'b0;
        on      = ((n / 10) % 2) == 1;
        blanked = 1'b0;
`ifdef LOCKIN_BLANKING_EN
        blanked = (n >= 10) && ((n % 10) < 2);
`endif
        w = (n + 4) / 100;
        if (!blanked && w < 4) begin
            if (on) exp_add[w][ch] = (exp_add[w][ch] < 255) ? exp_add[w][ch] + 1 : 255;
            else    exp_sub[w][ch] = (exp_sub[w][ch] < 255) ? exp_sub[w][ch] + 1 : 255;
        end
    endtask

    task automatic push_window(input int w);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int ch = 0; ch < NUM_CH; ch++)
            v[ch*RES_W +: RES_W] = RES_W'(exp_add[w][ch] - exp_sub[w][ch]);
        exp_q.push_back(v);
    endtask

    task automatic check_result(input string name);
        logic [VEC_W-1:0] exp_v;
        int budget = 0;
        exp_v = exp_q.pop_front();
        do begin
            @(negedge clock_50_mhz);
            budget++;
        end while (!result_valid && budget < 300);
        checks++;
        if (result_valid !== 1'b1 || result_diff !== exp_v) begin
            errors++;
            $display("FAIL %s: valid=%b diff=%h, required valid=1 diff=%h", name, result_valid, result_diff, exp_v);
        end
    endtask

    task automatic count_pulses(input int ch, input int span, output int hi);
        hi = 0;
        repeat (span) begin
            @(negedge clock_50_mhz);
            if (pulse_out_pin[ch]) hi++;
        end
    endtask

    task automatic test_reset();
        int pts[5] = '{5, 10, 15, 20, 35};
        reset_n = 1'b0; pmt_in = '0; pmt_sat = '0; result_ready = 1'b1; sat_ready = 1'b1;
        clear_model();
        repeat (3) @(negedge clock_50_mhz);
        checks++; if (light_source_pin !== 1'b0) begin errors++; $display("FAIL reset_light: got %b want 0", light_source_pin); end
        checks++; if (result_diff !== '0) begin errors++; $display("FAIL reset_diff: got %h want 0", result_diff); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (pulse_out_pin !== '0) begin errors++; $display("FAIL reset_pulse: got %b want 0", pulse_out_pin); end
        reset_n = 1'b1;
        foreach (pts[i]) begin
            wait_cyc(pts[i]);
            checks++;
            if (light_source_pin !== 1'((pts[i] / 10) % 2)) begin
                errors++;
                $display("FAIL modulation at cyc %0d: got %b want %0d", pts[i], light_source_pin, (pts[i] / 10) % 2);
            end
        end
    endtask

    task automatic test_phase_sort();
        int pulses[8] = '{2, 4, 6, 12, 14, 16, 18, 32};
        int hi, want;
        do_reset();
        foreach (pulses[i]) drive(0, pulses[i]);
        push_window(0);
        want = exp_add[0][0] - exp_sub[0][0];
        check_result("phase_sort");
        count_pulses(0, 12, hi);
        checks++;
        if (hi !== (want > 0 ? want : 0)) begin
            errors++; $display("FAIL phase_sort_pulse: high %0d cycles, want %0d", hi, want);
        end
    endtask

    task automatic test_negative();
        int pulses[4] = '{22, 24, 26, 28};
        int hi;
        do_reset();
        foreach (pulses[i]) drive(1, pulses[i]);
        push_window(0);
        check_result("negative");
        count_pulses(1, 12, hi);
        checks++;
        if (hi !== 0) begin errors++; $display("FAIL negative_pulse: high %0d cycles, want 0", hi); end
    endtask

    task automatic test_blanking();
        do_reset();
        drive(0, 10);
        drive(0, 15);
        drive(1, 20);
        push_window(0);
        check_result("blanking");
    endtask

    task automatic test_boundary();
        do_reset();
        drive(0, 94);
        drive(0, 96);
        push_window(0);
        push_window(1);
        check_result("boundary_w0");
        check_result("boundary_w1");
    endtask

    task automatic test_overrun();
        logic [VEC_W-1:0] exp_v;
        do_reset();
        result_ready = 1'b0;
        drive(0, 12);
        push_window(0);
        wait_cyc(100);
        exp_v = exp_q.pop_front();
        checks++; if (result_valid !== 1'b1 || result_diff !== exp_v) begin errors++; $display("FAIL overrun_first: valid=%b diff=%h want 1/%h", result_valid, result_diff, exp_v); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b want 0", overrun); end
        drive(0, 112);
        drive(0, 114);
        push_window(1);
        wait_cyc(200);
        exp_v = exp_q.pop_front();
        checks++; if (result_valid !== 1'b1 || result_diff !== exp_v) begin errors++; $display("FAIL overrun_second: valid=%b diff=%h want 1/%h", result_valid, result_diff, exp_v); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
        result_ready = 1'b1;
        @(negedge clock_50_mhz);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain: valid %b want 0", result_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_back_to_back();
        logic [VEC_W-1:0] exp_v;
        do_reset();
        result_ready = 1'b0;
        drive(1, 22);
        push_window(0);
        wait_cyc(100);
        exp_v = exp_q.pop_front();
        checks++; if (result_valid !== 1'b1 || result_diff !== exp_v) begin errors++; $display("FAIL b2b_first: valid=%b diff=%h want 1/%h", result_valid, result_diff, exp_v); end
        drive(1, 112);
        push_window(1);
        wait_cyc(199);
        result_ready = 1'b1;
        @(negedge clock_50_mhz);
        exp_v = exp_q.pop_front();
        checks++; if (result_valid !== 1'b1 || result_diff !== exp_v) begin errors++; $display("FAIL b2b_second: valid=%b diff=%h want 1/%h", result_valid, result_diff, exp_v); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        @(negedge clock_50_mhz);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL b2b_clear: valid %b want 0", result_valid); end
    endtask

    task automatic test_saturation();
        int cnt = 0;
        int hi = 0;
        int n;
        logic [VEC_W-1:0] exp_v;
        bit blanked;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            n = 710 + 2 * k;
            wait_cyc(n);
            pmt_sat[0] = 1'b1;
            @(negedge clock_50_mhz);
            pmt_sat[0] = 1'b0;
            blanked = 1'b0;
`ifdef LOCKIN_BLANKING_EN
            blanked = (n >= 700) && ((n % 700) < 2);
`endif
            if (((n / 700) % 2) == 1 && !blanked && cnt < 255) cnt++;
        end
        exp_v = '0;
        exp_v[RES_W-1:0] = RES_W'(cnt);
        exp_q.push_back(exp_v);
        wait_cyc(1400);
        exp_v = exp_q.pop_front();
        checks++; if (sat_valid !== 1'b1 || sat_diff !== exp_v) begin errors++; $display("FAIL saturation: valid=%b diff=%h want 1/%h", sat_valid, sat_diff, exp_v); end
        repeat (270) begin
            @(negedge clock_50_mhz);
            if (sat_pulse[0]) hi++;
        end
        checks++; if (hi !== cnt) begin errors++; $display("FAIL saturation_pulse: high %0d cycles, want %0d", hi, cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 12);
        drive(0, 14);
        wait_cyc(50);
        reset_n = 1'b0;
        #1;
        checks++; if (light_source_pin !== 1'b0) begin errors++; $display("FAIL midreset_light: got %b want 0", light_source_pin); end
        checks++; if (result_diff !== '0) begin errors++; $display("FAIL midreset_diff: got %h want 0", result_diff); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", result_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midreset_overrun: got %b want 0", overrun); end
        checks++; if (pulse_out_pin !== '0) begin errors++; $display("FAIL midreset_pulse: got %b want 0", pulse_out_pin); end
        clear_model();
        repeat (2) @(negedge clock_50_mhz);
        reset_n = 1'b1;
        drive(0, 12);
        push_window(0);
        check_result("reset_mid_first");
    endtask

    initial begin
        test_reset();
        test_phase_sort();
        test_negative();
        test_blanking();
        test_boundary();
        test_overrun();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
